// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and flag controller for a dual-clock FIFO: binary/Gray write
// pointer, registered full/almost_full, sticky overflow and a write-side fill level.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    input  logic                  winc,
    input  logic                  ovf_clr,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   wlevel
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    logic [PW-1:0]         wbin_q, wbin_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         wlevel_q, wlevel_d;
    logic [PW-1:0]         rbin_s;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic                  full_q, full_d;
    logic                  afull_q, afull_d;
    logic                  ovf_q, ovf_d;
    logic                  wen_int;

    // Handshake: winc is a request; it is accepted (wen=1) exactly when full is low.
    // A request while full is dropped and only recorded in the sticky overflow flag.
    always_comb begin
        wen_int = winc & ~full_q;
        wbin_d  = wbin_q + {{ADDR_WIDTH{1'b0}}, wen_int};
        wptr_d  = (wbin_d >> 1) ^ wbin_d;
        waddr_d = wbin_d[ADDR_WIDTH-1:0];

        rbin_s         = '0;
        rbin_s[PW-1]   = rptr_sync[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ rptr_sync[i];
        end

        // Modulo arithmetic makes the level correct across pointer wrap.
        wlevel_d = wbin_d - rbin_s;
        full_d   = (wptr_d == {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]});
        afull_d  = (wlevel_d >= AFULL_T);
        ovf_d    = (winc & full_q) | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            waddr_q  <= '0;
            wlevel_q <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            waddr_q  <= waddr_d;
            wlevel_q <= wlevel_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wen         = wen_int;
    assign waddr       = waddr_q;
    assign wptr        = wptr_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign overflow    = ovf_q;
    assign wlevel      = wlevel_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Bench for wptr_full_ctrl: directed phases plus random traffic, checked against
// a count-based FIFO model through an expected-result queue.
module tb_wptr_full_ctrl;

    logic       wclk = 1'b0;
    logic       rst_n;
    logic       winc;
    logic       ovf_clr;
    logic [3:0] rptr_sync;
    logic       wen;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic       full;
    logic       almost_full;
    logic       overflow;
    logic [3:0] wlevel;

    wptr_full_ctrl #(.ADDR_WIDTH(3), .AFULL_THRESH(6)) dut (
        .wclk        (wclk),
        .rst_n       (rst_n),
        .winc        (winc),
        .ovf_clr     (ovf_clr),
        .rptr_sync   (rptr_sync),
        .wen         (wen),
        .waddr       (waddr),
        .wptr        (wptr),
        .full        (full),
        .almost_full (almost_full),
        .overflow    (overflow),
        .wlevel      (wlevel)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       wen;
        logic [2:0] waddr;
        logic [3:0] wptr;
        logic       full;
        logic       afull;
        logic       ovf;
        logic [3:0] wlevel;
        logic       first;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Model: total words written / read as plain counts.
    int m_w     = 0;
    int m_r     = 0;
    bit m_full  = 0;
    bit m_ovf   = 0;
    bit m_first = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] to_gray(input int v);
        logic [3:0] b;
        b = 4'(v % 16);
        return b ^ (b >> 1);
    endfunction

    task automatic drive(input bit w, input bit c, input int rc);
        exp_t e;
        int   lvl;
        @(negedge wclk);
        winc      = w;
        ovf_clr   = c;
        rptr_sync = to_gray(rc);
        m_r       = rc;
        e.wen     = w && !m_full;
        e.first   = m_first;
        m_first   = 0;
        m_ovf     = (w && m_full) || (m_ovf && !c);
        if (e.wen) m_w++;
        lvl       = m_w - rc;
        m_full    = (lvl == 8);
        e.full    = m_full;
        e.afull   = (lvl >= 6);
        e.ovf     = m_ovf;
        e.wlevel  = 4'(lvl);
        e.waddr   = 3'(m_w % 8);
        e.wptr    = to_gray(m_w);
        exp_q.push_back(e);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_waddr"}, waddr, 0);
        check({tag, "_wptr"}, wptr, 0);
        check({tag, "_full"}, full, 0);
        check({tag, "_afull"}, almost_full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_wlevel"}, wlevel, 0);
    endtask

    task automatic do_reset();
        drive(0, 0, m_r);
        @(negedge wclk);
        #3;
        rst_n     = 1'b0;
        rptr_sync = 4'b0000;
        #1;
        check_zero("async_rst");
        winc = 1'b1;
        repeat (2) @(posedge wclk);
        #1;
        check_zero("held_rst");
        @(negedge wclk);
        winc    = 1'b0;
        rst_n   = 1'b1;
        m_w     = 0;
        m_r     = 0;
        m_full  = 0;
        m_ovf   = 0;
        m_first = 1;
    endtask

    // Monitor: samples wen before the edge and registered outputs after it.
    logic [3:0] prev_wptr = '0;
    initial begin : monitor
        exp_t       e;
        logic       wen_s;
        logic [3:0] d;
        forever begin
            @(negedge wclk);
            #2;
            if (exp_q.size() != 0) begin
                wen_s = wen;
                @(posedge wclk);
                #1;
                e = exp_q.pop_front();
                check("wen", wen_s, e.wen);
                check("waddr", waddr, e.waddr);
                check("wptr", wptr, e.wptr);
                check("full", full, e.full);
                check("almost_full", almost_full, e.afull);
                check("overflow", overflow, e.ovf);
                check("wlevel", wlevel, e.wlevel);
                if (!e.first) begin
                    d = wptr ^ prev_wptr;
                    check("gray_step", ($countones(d) <= 1), 1'b1);
                end
                prev_wptr = wptr;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int rc;
        int seg;
        rst_n     = 1'b0;
        winc      = 1'b1;
        ovf_clr   = 1'b0;
        rptr_sync = 4'b0000;
        repeat (2) @(posedge wclk);
        #1;
        check_zero("por");
        @(negedge wclk);
        winc  = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) drive(1, 0, 0);
        @(posedge wclk);
        #2;
        check("fill_full", full, 1);
        check("fill_wptr", wptr, 4'b1100);
        check("fill_wlevel", wlevel, 8);

        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        @(posedge wclk);
        #2;
        check("ovf_set_wins", overflow, 1);
        drive(0, 0, 0);

        drive(0, 0, 1);
        drive(0, 0, 3);

        drive(0, 1, 3);
        for (int i = 0; i < 40; i++) drive(1, 0, m_w - 1);

        for (int i = 0; i < 400; i++) begin
            seg = i / 100;
            rc  = m_r;
            if ($urandom_range(0, 3) < seg) rc = rc + $urandom_range(1, 2);
            if (rc > m_w) rc = m_w;
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, rc);
        end

        do_reset();
        for (int i = 0; i < 5; i++) drive(1, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 0);
        drive(0, 0, m_r);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge wclk);
        #3;
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
